bin_to_bcd_serial: RTL and testbench

Sequential double-dabble converter that takes the 32-bit binary value produced by the decimal-to-binary stage and produces packed BCD digits plus a sign flag. It sits directly downstream of that stage and upstream of the seven-segment display driver, which shows the Buscaminas mine counter and score. Conversion is iterative, one input bit per clock, with a start/busy/done handshake so the display logic latches only stable digits.

---
 rtl/buscaminas_pkg.sv | 19 +
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/bin_to_bcd_serial.sv | 129 ++++++++++++
 tb/tb_bin_to_bcd_serial.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the Buscaminas display datapath.
//   bcd_state_t    : FSM states of the serial binary-to-BCD converter
//   bcd_digit_t    : one packed BCD digit
//   BCD_ADJ_THRESH : digit value at or above which double-dabble adds a correction
//   BCD_ADJ_ADD    : the correction added to such a digit
package buscaminas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
//   digit_in    : current BCD digit
//   digit_adj_c : corrected digit (combinational); max value is 12, so no carry out
module bcd_digit_adjust
    import buscaminas_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_adj_c
);

    always_comb begin
        digit_adj_c = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_adj_c = digit_in + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock.
//   clk, rst  : clock and synchronous active-high reset
//   start     : request conversion of binary_in (accepted in IDLE or FINISH)
//   binary_in : value to convert (two's complement when SIGNED=1)
//   busy      : conversion in progress
//   done      : one-cycle pulse; bcd_out/sign/overflow valid from this cycle on
//   bcd_out   : packed BCD, digit 0 (units) in bits [3:0]
//   sign      : input was negative (SIGNED=1 only)
//   overflow  : magnitude did not fit in DIGITS digits
module bin_to_bcd_serial
    import buscaminas_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    binary_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                sign,
    output logic                overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    bcd_state_t       state;
    bcd_state_t       state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0] digits;
    logic [CNT_W-1:0] cnt;
    logic             ovf_sticky;
    logic             neg_q;

    logic             accept_c;
    logic             neg_in_c;
    logic [WIDTH-1:0] magnitude_c;
    logic [BCD_W-1:0] digits_adj_c;
    logic [BCD_W-1:0] digits_shift_c;
    logic             ovf_shift_c;

    // Per-digit add-3 correction ahead of each shift
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in    (digits[4*i +: 4]),
            .digit_adj_c (digits_adj_c[4*i +: 4])
        );
    end

    // Operand capture and one shift step of {digits, shift_reg}
    always_comb begin
        accept_c       = start && ((state == IDLE) || (state == FINISH));
        neg_in_c       = SIGNED && binary_in[WIDTH-1];
        magnitude_c    = neg_in_c ? ((~binary_in) + WIDTH'(1)) : binary_in;
        digits_shift_c = {digits_adj_c[BCD_W-2:0], shift_reg[WIDTH-1]};
        // A set MSB in the corrected top digit is about to fall off the end
        ovf_shift_c    = ovf_sticky | digits_adj_c[BCD_W-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) state_next = FINISH;
            end
            FINISH: begin
                state_next = accept_c ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            digits     <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            neg_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            sign       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == FINISH);

            if (accept_c) begin
                shift_reg  <= magnitude_c;
                digits     <= '0;
                cnt        <= CNT_W'(WIDTH);
                ovf_sticky <= 1'b0;
                neg_q      <= neg_in_c;
            end else if (state == SHIFT) begin
                shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
                digits     <= digits_shift_c;
                cnt        <= cnt - CNT_W'(1);
                ovf_sticky <= ovf_shift_c;
            end

            // Result lands together with done; held until the next FINISH
            if ((state == SHIFT) && (state_next == FINISH)) begin
                bcd_out  <= digits_shift_c;
                overflow <= ovf_shift_c;
                sign     <= neg_q;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed bench for bin_to_bcd_serial: signed 32-bit, unsigned 32-bit and
// an 8-bit/2-digit instance for the overflow boundary.
module tb_bin_to_bcd_serial;

    logic        clk;
    logic        rst;

    logic        start_s, busy_s, done_s, sign_s, ovf_s;
    logic [31:0] bin_s;
    logic [39:0] bcd_s;

    logic        start_u, busy_u, done_u, sign_u, ovf_u;
    logic [31:0] bin_u;
    logic [39:0] bcd_u;

    logic        start_8, busy_8, done_8, sign_8, ovf_8;
    logic [7:0]  bin_8;
    logic [7:0]  bcd_8;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_serial #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .binary_in(bin_s),
        .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .sign(sign_s), .overflow(ovf_s)
    );

    bin_to_bcd_serial #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .binary_in(bin_u),
        .busy(busy_u), .done(done_u), .bcd_out(bcd_u), .sign(sign_u), .overflow(ovf_u)
    );

    bin_to_bcd_serial #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0)) dut_8 (
        .clk(clk), .rst(rst), .start(start_8), .binary_in(bin_8),
        .busy(busy_8), .done(done_8), .bcd_out(bcd_8), .sign(sign_8), .overflow(ovf_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sel_done(input int which);
        case (which)
            0:       return done_s;
            1:       return done_u;
            default: return done_8;
        endcase
    endfunction

    // Runs one conversion; lat is the cycle index (start sample = cycle 0) of done
    task automatic convert(input int which, input logic [31:0] val,
                           output logic [39:0] bcd, output logic sgn,
                           output logic ovf, output int lat);
        case (which)
            0:       begin bin_s = val;      start_s = 1'b1; end
            1:       begin bin_u = val;      start_u = 1'b1; end
            default: begin bin_8 = val[7:0]; start_8 = 1'b1; end
        endcase
        @(posedge clk); #1;
        start_s = 1'b0; start_u = 1'b0; start_8 = 1'b0;
        lat = 1;
        while (!sel_done(which) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        case (which)
            0:       begin bcd = bcd_s;          sgn = sign_s; ovf = ovf_s; end
            1:       begin bcd = bcd_u;          sgn = sign_u; ovf = ovf_u; end
            default: begin bcd = {32'd0, bcd_8}; sgn = sign_8; ovf = ovf_8; end
        endcase
    endtask

    task automatic test_reset;
        logic [39:0] bcd;
        logic        sgn, ovf;
        int          lat;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy_s, done_s, sign_s, ovf_s} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/sign/ovf=%b expected 0000",
                     {busy_s, done_s, sign_s, ovf_s});
        end
        checks++;
        if (bcd_s !== 40'h0) begin
            errors++;
            $display("FAIL reset_bcd: got %h expected 0", bcd_s);
        end
        convert(0, 32'd0, bcd, sgn, ovf, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 33", lat);
        end
        checks++;
        if ({bcd, sgn, ovf} !== 42'h0) begin
            errors++;
            $display("FAIL zero_result: bcd=%h sign=%b ovf=%b expected 0/0/0", bcd, sgn, ovf);
        end
    endtask

    task automatic test_unsigned_full;
        logic [39:0] bcd;
        logic        sgn, ovf;
        int          lat;
        convert(1, 32'hFFFF_FFFF, bcd, sgn, ovf, lat);
        checks++;
        if (bcd !== 40'h4294967295 || ovf !== 1'b0 || sgn !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_full: bcd=%h sign=%b ovf=%b expected 4294967295/0/0",
                     bcd, sgn, ovf);
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL unsigned_latency: got %0d expected 33", lat);
        end
    endtask

    task automatic test_signed_neg;
        logic [39:0] bcd;
        logic        sgn, ovf;
        int          lat;
        convert(0, 32'hFFFF_FFFF, bcd, sgn, ovf, lat);
        checks++;
        if (bcd !== 40'h0000000001 || sgn !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL signed_minus1: bcd=%h sign=%b ovf=%b expected 0000000001/1/0",
                     bcd, sgn, ovf);
        end
        convert(0, 32'h8000_0000, bcd, sgn, ovf, lat);
        checks++;
        if (bcd !== 40'h2147483648 || sgn !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL signed_min: bcd=%h sign=%b ovf=%b expected 2147483648/1/0",
                     bcd, sgn, ovf);
        end
        convert(0, 32'd905, bcd, sgn, ovf, lat);
        checks++;
        if (bcd !== 40'h905 || sgn !== 1'b0) begin
            errors++;
            $display("FAIL signed_pos: bcd=%h sign=%b expected 905/0", bcd, sgn);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int done_count = 0;
        logic both_high = 1'b0;
        bin_s = 32'd1234; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        cyc = 1;
        while (done_count < 2 && cyc < 120) begin
            if (busy_s && done_s) both_high = 1'b1;
            start_s = 1'b0;
            if (cyc == 10) begin
                bin_s = 32'd99; start_s = 1'b1;
            end
            if (cyc == 34) begin
                checks++;
                if (busy_s !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_busy: busy=%b at cycle 34 expected 1", busy_s);
                end
            end
            if (cyc == 50) begin
                checks++;
                if (bcd_s !== 40'h1234) begin
                    errors++;
                    $display("FAIL hold_output: got %h expected 1234", bcd_s);
                end
            end
            if (done_s) begin
                done_count++;
                if (done_count == 1) begin
                    checks++;
                    if (cyc !== 33 || bcd_s !== 40'h1234) begin
                        errors++;
                        $display("FAIL first_done: cycle=%0d bcd=%h expected 33/1234", cyc, bcd_s);
                    end
                    bin_s = 32'd56; start_s = 1'b1;
                end else begin
                    checks++;
                    if (cyc !== 66 || bcd_s !== 40'h56) begin
                        errors++;
                        $display("FAIL second_done: cycle=%0d bcd=%h expected 66/56", cyc, bcd_s);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_s = 1'b0;
        checks++;
        if (done_count !== 2) begin
            errors++;
            $display("FAIL b2b_timeout: saw %0d done pulses expected 2", done_count);
        end
        checks++;
        if (both_high !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_overlap: got %b expected 0", both_high);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        logic saw_done = 1'b0;
        bin_s = 32'd777; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || bcd_s !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b bcd=%h expected 0/0/0", busy_s, done_s, bcd_s);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done_s) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %b expected 0", saw_done);
        end
    endtask

    task automatic test_overflow;
        logic [39:0] bcd;
        logic        sgn, ovf;
        int          lat;
        convert(2, 32'd100, bcd, sgn, ovf, lat);
        checks++;
        if (ovf !== 1'b1 || lat !== 9) begin
            errors++;
            $display("FAIL overflow_100: ovf=%b latency=%0d expected 1/9", ovf, lat);
        end
        convert(2, 32'd99, bcd, sgn, ovf, lat);
        checks++;
        if (ovf !== 1'b0 || bcd[7:0] !== 8'h99 || sgn !== 1'b0) begin
            errors++;
            $display("FAIL overflow_99: ovf=%b bcd=%h sign=%b expected 0/99/0", ovf, bcd[7:0], sgn);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_s = 1'b0; start_u = 1'b0; start_8 = 1'b0;
        bin_s = '0; bin_u = '0; bin_8 = '0;
        test_reset();
        test_unsigned_full();
        test_signed_neg();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
